// File: rtl/reg_bus_master_if.sv
// Signal bundle for reg_bus_master: request/response handshakes plus the 16-bit register bus.
// The master modport is the initiator's view; slave is the view of whoever sits around it.
interface reg_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic        req_wide;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_op;
    logic [31:0] rsp_rdata;
    logic        bus_cmd_valid;
    logic        bus_op;
    logic [15:0] bus_addr;
    logic [15:0] bus_wr_data;
    logic [15:0] bus_rd_data;

    modport master (
        input  req_valid, req_op, req_wide, req_addr, req_wdata, rsp_ready, bus_rd_data,
        output req_ready, rsp_valid, rsp_op, rsp_rdata,
               bus_cmd_valid, bus_op, bus_addr, bus_wr_data
    );

    modport slave (
        output req_valid, req_op, req_wide, req_addr, req_wdata, rsp_ready, bus_rd_data,
        input  req_ready, rsp_valid, rsp_op, rsp_rdata,
               bus_cmd_valid, bus_op, bus_addr, bus_wr_data
    );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns one accepted request into one or two 16-bit bus beats
// (wide = high half at addr, low half at addr+1) and returns a held response.
module reg_bus_master #(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, RSP} state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t      state;
    logic        op_q;
    logic        wide_q;
    logic        beat_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] rdata_hi_q;
    logic [2:0]  lat_cnt;

    assign bus.req_ready = (state == IDLE) && rst_n;

    // Bus and response outputs are loaded on the edge entering the state that shows them,
    // so every output except req_ready comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            op_q              <= 1'b0;
            wide_q            <= 1'b0;
            beat_q            <= 1'b0;
            addr_q            <= 16'h0000;
            wdata_q           <= 32'h0000_0000;
            rdata_hi_q        <= 16'h0000;
            lat_cnt           <= 3'd0;
            bus.bus_cmd_valid <= 1'b0;
            bus.bus_op        <= 1'b0;
            bus.bus_addr      <= 16'h0000;
            bus.bus_wr_data   <= 16'h0000;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_op        <= 1'b0;
            bus.rsp_rdata     <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state             <= CMD;
                        op_q              <= bus.req_op;
                        wide_q            <= bus.req_wide;
                        addr_q            <= bus.req_addr;
                        wdata_q           <= bus.req_wdata;
                        beat_q            <= 1'b0;
                        rdata_hi_q        <= 16'h0000;
                        bus.bus_cmd_valid <= 1'b1;
                        bus.bus_op        <= bus.req_op;
                        bus.bus_addr      <= bus.req_addr;
                        bus.bus_wr_data   <= !bus.req_op ? 16'h0000 :
                                             bus.req_wide ? bus.req_wdata[31:16] :
                                                            bus.req_wdata[15:0];
                    end
                end

                CMD: begin
                    if (op_q && wide_q && !beat_q) begin
                        // Wide writes issue the low half back-to-back with the high half.
                        beat_q          <= 1'b1;
                        bus.bus_addr    <= addr_q + 16'd1;
                        bus.bus_wr_data <= wdata_q[15:0];
                    end else begin
                        bus.bus_cmd_valid <= 1'b0;
                        bus.bus_op        <= 1'b0;
                        bus.bus_addr      <= 16'h0000;
                        bus.bus_wr_data   <= 16'h0000;
                        if (op_q) begin
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_op    <= 1'b1;
                            bus.rsp_rdata <= 32'h0000_0000;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 3'd0;
                        end
                    end
                end

                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (wide_q && !beat_q) begin
                            rdata_hi_q        <= bus.bus_rd_data;
                            beat_q            <= 1'b1;
                            state             <= CMD;
                            bus.bus_cmd_valid <= 1'b1;
                            bus.bus_op        <= 1'b0;
                            bus.bus_addr      <= addr_q + 16'd1;
                            bus.bus_wr_data   <= 16'h0000;
                        end else begin
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_op    <= 1'b0;
                            bus.rsp_rdata <= {(wide_q ? rdata_hi_q : 16'h0000), bus.bus_rd_data};
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end

                RSP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_op    <= 1'b0;
                        bus.rsp_rdata <= 32'h0000_0000;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: cycle-exact vector table, directed corner sequences, and a
// randomized run scored against a transaction-level model of beats and responses.
module tb_reg_bus_master;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_bus_master_if ifa();
    reg_bus_master_if ifb();

    reg_bus_master #(.RD_LAT(LAT_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    reg_bus_master #(.RD_LAT(LAT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic        op;
        logic        wide;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [15:0] b0_data;
        int          b1_cyc;
        logic [15:0] b1_addr;
        logic [15:0] b1_data;
        int          rsp_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    typedef struct packed {
        logic        op;
        logic [31:0] rdata;
    } rsp_t;

    int    checks = 0;
    int    errors = 0;
    logic  model_on = 1'b0;
    logic  rand_on = 1'b0;
    logic  rsp_force = 1'b1;
    logic  rsp_rand = 1'b1;
    beat_t exp_beats[$];
    rsp_t  exp_rsps[$];

    logic [15:0] slave_mem [65536];
    logic        hist_a_v [4];
    logic [15:0] hist_a_addr [4];
    logic        hist_b_v [4];
    logic [15:0] hist_b_addr [4];

    assign ifa.rsp_ready = rand_on ? rsp_rand : rsp_force;
    assign ifb.rsp_ready = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Read slaves: data appears exactly RD_LAT cycles after a read beat, random garbage otherwise.
    always @(negedge clk) begin
        for (int i = 3; i > 0; i--) begin
            hist_a_v[i]    = hist_a_v[i-1];
            hist_a_addr[i] = hist_a_addr[i-1];
            hist_b_v[i]    = hist_b_v[i-1];
            hist_b_addr[i] = hist_b_addr[i-1];
        end
        hist_a_v[0]    = ifa.bus_cmd_valid && !ifa.bus_op;
        hist_a_addr[0] = ifa.bus_addr;
        hist_b_v[0]    = ifb.bus_cmd_valid && !ifb.bus_op;
        hist_b_addr[0] = ifb.bus_addr;
    end

    always @(posedge clk) begin
        #1;
        ifa.bus_rd_data = hist_a_v[LAT_A-1] ? slave_mem[hist_a_addr[LAT_A-1]] : 16'($urandom);
        ifb.bus_rd_data = hist_b_v[LAT_B-1] ? slave_mem[hist_b_addr[LAT_B-1]] : 16'($urandom);
        rsp_rand        = ($urandom_range(0, 3) != 0);
    end

    task automatic applyStimulus(input logic op, input logic wide, input logic [15:0] addr,
                                 input logic [31:0] wdata);
        int          n;
        logic [15:0] addr1;
        n     = 0;
        addr1 = addr + 16'd1;
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_op    = op;
        ifa.req_wide  = wide;
        ifa.req_addr  = addr;
        ifa.req_wdata = wdata;
        while (!ifa.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_accept", 32'(ifa.req_ready), 32'd1);
        if (ifa.req_ready && model_on) begin
            if (wide) begin
                exp_beats.push_back('{op, addr,  op ? wdata[31:16] : 16'h0000});
                exp_beats.push_back('{op, addr1, op ? wdata[15:0]  : 16'h0000});
            end else begin
                exp_beats.push_back('{op, addr, op ? wdata[15:0] : 16'h0000});
            end
            if (op)
                exp_rsps.push_back('{1'b1, 32'h0000_0000});
            else if (wide)
                exp_rsps.push_back('{1'b0, {slave_mem[addr], slave_mem[addr1]}});
            else
                exp_rsps.push_back('{1'b0, {16'h0000, slave_mem[addr]}});
        end
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
    endtask

    // Transaction monitor for the randomized phase.
    logic        prev_cmd = 1'b0;
    logic        hold_pend = 1'b0;
    logic        held_op;
    logic [31:0] held_rdata;
    always @(negedge clk) begin
        if (rand_on) begin
            if (ifa.bus_cmd_valid) begin
                checkOutput("read_beats_adjacent", 32'(prev_cmd && !ifa.bus_op), 32'd0);
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got beat at addr %h, expected no beat", ifa.bus_addr);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    checkOutput("rand_bus_op",   32'(ifa.bus_op),      32'(b.op));
                    checkOutput("rand_bus_addr", 32'(ifa.bus_addr),    32'(b.addr));
                    checkOutput("rand_bus_data", 32'(ifa.bus_wr_data), 32'(b.data));
                end
            end
            prev_cmd = ifa.bus_cmd_valid;
            if (hold_pend) begin
                checkOutput("hold_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
                checkOutput("hold_rsp_op",    32'(ifa.rsp_op),    32'(held_op));
                checkOutput("hold_rsp_rdata", ifa.rsp_rdata,      held_rdata);
            end
            hold_pend  = ifa.rsp_valid && !ifa.rsp_ready;
            held_op    = ifa.rsp_op;
            held_rdata = ifa.rsp_rdata;
            if (ifa.rsp_valid && ifa.rsp_ready) begin
                if (exp_rsps.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rdata %h, expected no response", ifa.rsp_rdata);
                end else begin
                    rsp_t r;
                    r = exp_rsps.pop_front();
                    checkOutput("rand_rsp_op",    32'(ifa.rsp_op), 32'(r.op));
                    checkOutput("rand_rsp_rdata", ifa.rsp_rdata,   r.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[7];

    initial begin
        int   n;
        logic beat;

        vecs[0] = '{1'b1, 1'b0, 16'h0009, 32'h0000_0001, 16'h0001, 0, 16'h0000, 16'h0000, 2, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 16'h0005, 32'h1234_5678, 16'h1234, 2, 16'h0006, 16'h5678, 3, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 32'hDEAD_BEEF, 16'hDEAD, 2, 16'h0000, 16'hBEEF, 3, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 16'h1234, 32'hABCD_0042, 16'h0042, 0, 16'h0000, 16'h0000, 2, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b1, 16'h0005, 32'hFFFF_FFFF, 16'h0000, 3, 16'h0006, 16'h0000, 5, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 16'h0009, 32'h5555_AAAA, 16'h0000, 0, 16'h0000, 16'h0000, 3, 32'h0000_0001};
        vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 32'h0000_0000, 16'h0000, 3, 16'h0000, 16'h0000, 5, 32'hBEEF_CAFE};

        for (int i = 0; i < 65536; i++) slave_mem[i] = 16'($urandom);
        slave_mem[16'h0005] = 16'h1234;
        slave_mem[16'h0006] = 16'h5678;
        slave_mem[16'h0009] = 16'h0001;
        slave_mem[16'hFFFF] = 16'hBEEF;
        slave_mem[16'h0000] = 16'hCAFE;
        for (int i = 0; i < 4; i++) begin
            hist_a_v[i] = 1'b0; hist_a_addr[i] = 16'h0000;
            hist_b_v[i] = 1'b0; hist_b_addr[i] = 16'h0000;
        end
        ifa.req_valid = 1'b0; ifa.req_op = 1'b0; ifa.req_wide = 1'b0;
        ifa.req_addr = 16'h0000; ifa.req_wdata = 32'h0;
        ifb.req_valid = 1'b0; ifb.req_op = 1'b0; ifb.req_wide = 1'b0;
        ifb.req_addr = 16'h0000; ifb.req_wdata = 32'h0;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_req_ready",     32'(ifa.req_ready),     32'd1);
        checkOutput("rst_rsp_valid",     32'(ifa.rsp_valid),     32'd0);
        checkOutput("rst_rsp_op",        32'(ifa.rsp_op),        32'd0);
        checkOutput("rst_rsp_rdata",     ifa.rsp_rdata,          32'd0);
        checkOutput("rst_bus_cmd_valid", 32'(ifa.bus_cmd_valid), 32'd0);
        checkOutput("rst_bus_op",        32'(ifa.bus_op),        32'd0);
        checkOutput("rst_bus_addr",      32'(ifa.bus_addr),      32'd0);
        checkOutput("rst_bus_wr_data",   32'(ifa.bus_wr_data),   32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].wide, vecs[i].addr, vecs[i].wdata);
            for (int k = 1; k <= vecs[i].rsp_cyc + 1; k++) begin
                @(negedge clk);
                beat = (k == 1) || (k == vecs[i].b1_cyc);
                checkOutput($sformatf("v%0d_c%0d_cmd_valid", i, k), 32'(ifa.bus_cmd_valid), 32'(beat));
                if (k == 1) begin
                    checkOutput($sformatf("v%0d_b0_op", i),   32'(ifa.bus_op),      32'(vecs[i].op));
                    checkOutput($sformatf("v%0d_b0_addr", i), 32'(ifa.bus_addr),    32'(vecs[i].addr));
                    checkOutput($sformatf("v%0d_b0_data", i), 32'(ifa.bus_wr_data), 32'(vecs[i].b0_data));
                end else if (beat) begin
                    checkOutput($sformatf("v%0d_b1_op", i),   32'(ifa.bus_op),      32'(vecs[i].op));
                    checkOutput($sformatf("v%0d_b1_addr", i), 32'(ifa.bus_addr),    32'(vecs[i].b1_addr));
                    checkOutput($sformatf("v%0d_b1_data", i), 32'(ifa.bus_wr_data), 32'(vecs[i].b1_data));
                end else begin
                    checkOutput($sformatf("v%0d_c%0d_idle_addr", i, k), 32'(ifa.bus_addr),    32'd0);
                    checkOutput($sformatf("v%0d_c%0d_idle_data", i, k), 32'(ifa.bus_wr_data), 32'd0);
                end
                checkOutput($sformatf("v%0d_c%0d_rsp_valid", i, k), 32'(ifa.rsp_valid), 32'(k == vecs[i].rsp_cyc));
                checkOutput($sformatf("v%0d_c%0d_req_ready", i, k), 32'(ifa.req_ready), 32'(k == vecs[i].rsp_cyc + 1));
                if (k == vecs[i].rsp_cyc) begin
                    checkOutput($sformatf("v%0d_rsp_op", i),    32'(ifa.rsp_op), 32'(vecs[i].op));
                    checkOutput($sformatf("v%0d_rsp_rdata", i), ifa.rsp_rdata,   vecs[i].exp_rdata);
                end
            end
        end

        $display("[TB] response backpressure");
        rsp_force = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0009, 32'h0);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("bp%0d_rsp_valid", j), 32'(ifa.rsp_valid),     32'd1);
            checkOutput($sformatf("bp%0d_rsp_rdata", j), ifa.rsp_rdata,          32'h0000_0001);
            checkOutput($sformatf("bp%0d_req_ready", j), 32'(ifa.req_ready),     32'd0);
            checkOutput($sformatf("bp%0d_cmd_valid", j), 32'(ifa.bus_cmd_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("bp_rsp_valid_before_hs", 32'(ifa.rsp_valid), 32'd1);
        rsp_force = 1'b1;
        @(negedge clk);
        checkOutput("bp_req_ready_after_hs", 32'(ifa.req_ready), 32'd1);
        checkOutput("bp_rsp_valid_after_hs", 32'(ifa.rsp_valid), 32'd0);

        $display("[TB] narrow read with RD_LAT=3");
        @(negedge clk);
        ifb.req_valid = 1'b1;
        ifb.req_op    = 1'b0;
        ifb.req_wide  = 1'b0;
        ifb.req_addr  = 16'h0009;
        ifb.req_wdata = 32'($urandom);
        checkOutput("lat3_req_ready", 32'(ifb.req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifb.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("lat3_c%0d_cmd_valid", k), 32'(ifb.bus_cmd_valid), 32'(k == 1));
            checkOutput($sformatf("lat3_c%0d_rsp_valid", k), 32'(ifb.rsp_valid),     32'(k == 5));
            if (k == 1) checkOutput("lat3_bus_addr", 32'(ifb.bus_addr), 32'h0009);
            if (k == 5) begin
                checkOutput("lat3_rsp_rdata", ifb.rsp_rdata,   32'h0000_0001);
                checkOutput("lat3_rsp_op",    32'(ifb.rsp_op), 32'd0);
            end
        end

        $display("[TB] reset during wide read");
        applyStimulus(1'b0, 1'b1, 16'h0005, 32'h0);
        @(negedge clk);
        checkOutput("mid_rst_beat0", 32'(ifa.bus_cmd_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_req_ready", 32'(ifa.req_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("mid_rst_c%0d_cmd_valid", k), 32'(ifa.bus_cmd_valid), 32'd0);
            checkOutput($sformatf("mid_rst_c%0d_rsp_valid", k), 32'(ifa.rsp_valid),     32'd0);
            checkOutput($sformatf("mid_rst_c%0d_req_ready", k), 32'(ifa.req_ready),     32'd1);
            @(negedge clk);
        end

        $display("[TB] randomized traffic");
        model_on = 1'b1;
        rand_on  = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [15:0] addr;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom);
        end
        n = 0;
        while (exp_rsps.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_rsps",  32'(exp_rsps.size()),  32'd0);
        checkOutput("drain_beats", 32'(exp_beats.size()), 32'd0);
        rand_on  = 1'b0;
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Initiator for the 16-bit register bus (`bus_cmd_valid` / `bus_op` / `bus_addr` / `bus_wr_data` / `bus_rd_data`). It accepts one register request at a time on a valid/ready request port and converts it into one or two bus command cycles. It captures read data after the slave's fixed read latency and returns a response on a valid/ready response port. Wide (32-bit) accesses map onto adjacent 16-bit registers, high half at `addr` and low half at `addr+1`, which matches the split-counter register layout used by the bus slaves.

## Interface
- `RD_LAT`, default 1: cycles from a read command cycle to the cycle in which `bus_rd_data` is sampled; legal range 1..4.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_op` in 1: 1 = write, 0 = read.
- `req_wide` in 1: 1 = 32-bit access (two beats), 0 = 16-bit access.
- `req_addr` in 16: register address; for wide accesses this is the high-half address.
- `req_wdata` in 32: write data; narrow writes use `[15:0]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_op` out 1: copy of `req_op` for the request being answered.
- `rsp_rdata` out 32: read data; 0 for writes; narrow reads zero-extended.
- `bus_cmd_valid` out 1: bus command cycle.
- `bus_op` out 1: 1 = write.
- `bus_addr` out 16: bus address.
- `bus_wr_data` out 16: bus write data.
- `bus_rd_data` in 16: slave read data.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - CMD: one bus command cycle.
  - WAIT: read-latency count.
  - RSP: response is held.
- IDLE → CMD on request accept. All request fields are registered and a beat index is set to 0.
- CMD:
  - Drives `bus_cmd_valid` = 1 for exactly one cycle.
  - `bus_addr` = `addr` on beat 0, `addr+1` on beat 1. The 16-bit add wraps, so 16'hFFFF+1 = 16'h0000.
  - Writes: `bus_wr_data` = `wdata[31:16]` on wide beat 0, `wdata[15:0]` on the last beat (narrow, or wide beat 1).
  - Reads: `bus_wr_data` = 0.
- CMD exit:
  - Write with a beat remaining → CMD (beat 1).
  - Write, last beat → RSP.
  - Read → WAIT.
- WAIT counts `RD_LAT` cycles, then samples `bus_rd_data` on the edge ending the last WAIT cycle.
  - Wide beat 0: sample lands in `rdata[31:16]`.
  - Last beat: sample lands in `rdata[15:0]`.
- WAIT exit: beat remaining → CMD (beat 1); otherwise → RSP.
- RSP:
  - `rsp_valid` = 1.
  - `rsp_op`, `rsp_rdata` are stable until `rsp_ready`.
  - On handshake → IDLE.
- `req_ready` = (state == IDLE) && `rst_n`. Only one request is outstanding; there is no request/response overlap.
- When `bus_cmd_valid` = 0, `bus_op`, `bus_addr` and `bus_wr_data` are driven 0.
- All outputs are registered except `req_ready`.
- Reset (`rst_n` = 0 at an edge), including mid-operation:
  - State → IDLE.
  - The outstanding request is dropped: no further bus beats, no response.
  - All registered outputs → 0.

## Timing
- Request accepted on the edge ending cycle A.
- Narrow write: command in A+1; `rsp_valid` from A+2.
- Wide write: commands in A+1 and A+2, back-to-back; `rsp_valid` from A+3.
- Narrow read: command in A+1; sample at the end of A+1+`RD_LAT`; `rsp_valid` from A+2+`RD_LAT`.
- Wide read: commands in A+1 and A+2+`RD_LAT`; `rsp_valid` from A+3+2·`RD_LAT`. With `RD_LAT` = 1: commands at A+1 and A+3, response at A+5.
- Response handshake on the edge ending cycle R; `req_ready` = 1 in cycle R+1.
- `bus_cmd_valid` is never high in two consecutive cycles on reads; it is high in two consecutive cycles only for wide writes.
- In the first cycle after reset release: `req_ready` = 1, all other outputs 0.

## Test plan
- Narrow write, `addr` 16'h0009, `wdata` 32'h0000_0001 → A+1: `bus_cmd_valid` = 1, `op` = 1, `addr` 16'h0009, `wr_data` 16'h0001; A+2: `rsp_valid` = 1, `rsp_op` = 1, `rsp_rdata` = 0.
- Wide write, `addr` 16'h0005, `wdata` 32'h1234_5678 → A+1: `addr` 5, data 16'h1234; A+2: `addr` 6, data 16'h5678; `rsp_valid` at A+3.
- Wide read, `addr` 5, `RD_LAT` = 1, slave returns 16'h1234 then 16'h5678 → command beats at A+1 and A+3; `rsp_rdata` = 32'h1234_5678, `rsp_op` = 0 at A+5.
- Narrow read, `addr` 9, `RD_LAT` = 3, slave returns 16'h0001 only in cycle A+4 (garbage otherwise) → `rsp_rdata` = 32'h0000_0001 at A+5.
- Backpressure: `rsp_ready` low for 3 cycles during a response → `rsp_valid` and `rsp_rdata` are held unchanged, `req_ready` = 0, no bus activity; `req_ready` = 1 the cycle after the handshake.
- Wrap: wide write at `addr` 16'hFFFF → beat 1 has `addr` 16'h0000.
- Reset mid-operation: reset asserted the cycle after wide-read beat 0 → no second command, `rsp_valid` never asserts, `req_ready` = 1 after reset release.
